// File: rtl/baccarat_pkg.sv
// Shared card types and scoring helpers for the baccarat datapath and statemachine.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_MIN   = 4'd1;
  localparam card_t CARD_MAX   = 4'd13;

  // Win-light pair {player_win_light, dealer_win_light}
  typedef enum logic [1:0] {
    ResNone   = 2'b00,
    ResDealer = 2'b01,
    ResPlayer = 2'b10,
    ResTie    = 2'b11
  } result_e;

  // Face cards, tens and the empty slot are worth nothing.
  function automatic logic [3:0] card_value(input card_t card);
    return (card >= CARD_MIN && card <= 4'd9) ? card : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    // sum is at most 27, so two conditional subtractions implement mod 10
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/dealcard.sv
// Free-running card source: cycles 1..13 on every clock edge, never produces an empty code.
module dealcard
  import baccarat_pkg::*;
#(
  parameter int unsigned CARD_SEED = 1
) (
  input  logic  slow_clock,
  input  logic  resetb,
  output card_t new_card
);

  // An illegal seed would otherwise let the counter emit 0 or 14/15.
  localparam card_t SeedCard = (CARD_SEED >= 1 && CARD_SEED <= 13) ? card_t'(CARD_SEED)
                                                                   : CARD_MIN;

  card_t card_q;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_q <= SeedCard;
    end else if (card_q == CARD_MAX) begin
      card_q <= CARD_MIN;
    end else begin
      card_q <= card_q + 4'd1;
    end
  end

  assign new_card = card_q;

endmodule

// File: rtl/card_datapath.sv
// Baccarat datapath: hand registers loaded from the card source, hand scores, and round tallies
// derived from the statemachine's win lights.
module card_datapath
  import baccarat_pkg::*;
#(
  parameter int unsigned TALLY_W   = 8,
  parameter int unsigned CARD_SEED = 1
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               load_pcard1,
  input  logic               load_pcard2,
  input  logic               load_pcard3,
  input  logic               load_dcard1,
  input  logic               load_dcard2,
  input  logic               load_dcard3,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);

  card_t       new_card;
  card_t       slot_q [6];
  logic  [5:0] load;

  dealcard #(
    .CARD_SEED (CARD_SEED)
  ) u_dealcard (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .new_card   (new_card)
  );

  // Slots 0..2 are player cards 1..3, slots 3..5 dealer cards 1..3.
  assign load = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

  // Simultaneous strobes all capture the same card; no priority between slots.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) begin
        slot_q[i] <= CARD_EMPTY;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (load[i]) begin
          slot_q[i] <= new_card;
        end
      end
    end
  end

  assign pcard1 = slot_q[0];
  assign pcard2 = slot_q[1];
  assign pcard3 = slot_q[2];
  assign dcard1 = slot_q[3];
  assign dcard2 = slot_q[4];
  assign dcard3 = slot_q[5];

  assign pscore = hand_score(slot_q[0], slot_q[1], slot_q[2]);
  assign dscore = hand_score(slot_q[3], slot_q[4], slot_q[5]);

  result_e            result;
  result_e            prev_result_q;
  logic [TALLY_W-1:0] player_wins_q;
  logic [TALLY_W-1:0] dealer_wins_q;
  logic [TALLY_W-1:0] ties_q;

  assign result = result_e'({player_win_light, dealer_win_light});

  // A round is counted only on the rising edge out of the all-dark state, so lights that stay
  // lit or change colour without going dark are counted once.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      prev_result_q <= ResNone;
      player_wins_q <= '0;
      dealer_wins_q <= '0;
      ties_q        <= '0;
    end else begin
      prev_result_q <= result;
      if (prev_result_q == ResNone) begin
        unique case (result)
          ResPlayer: if (player_wins_q != '1) player_wins_q <= player_wins_q + TALLY_W'(1);
          ResDealer: if (dealer_wins_q != '1) dealer_wins_q <= dealer_wins_q + TALLY_W'(1);
          ResTie:    if (ties_q != '1)        ties_q        <= ties_q + TALLY_W'(1);
          ResNone:   ;
        endcase
      end
    end
  end

  assign player_wins = player_wins_q;
  assign dealer_wins = dealer_wins_q;
  assign ties        = ties_q;

endmodule

// File: tb/tb_card_datapath.sv
// Randomised and directed bench for card_datapath against a high-level round/card model.
module tb_card_datapath;

  logic       clk = 1'b0;
  logic       resetb;
  logic [5:0] ld;
  logic [1:0] lt;

  always #5 clk = ~clk;

  logic [3:0] card_o [2][6];
  logic [3:0] ps [2];
  logic [3:0] ds [2];
  logic [7:0] pw_a, dw_a, ti_a;
  logic [1:0] pw_b, dw_b, ti_b;

  int checks = 0;
  int errors = 0;

  // Model: per DUT card counter, six slots, three tallies; shared previous lights.
  int cnt [2];
  int slot [2][6];
  int tal [2][3];
  int prev_res;
  int maxv [2] = '{255, 3};
  int seed [2] = '{1, 7};

  card_datapath #(.TALLY_W(8), .CARD_SEED(1)) dut_a (
    .slow_clock(clk), .resetb(resetb),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(lt[1]), .dealer_win_light(lt[0]),
    .pcard1(card_o[0][0]), .pcard2(card_o[0][1]), .pcard3(card_o[0][2]),
    .dcard1(card_o[0][3]), .dcard2(card_o[0][4]), .dcard3(card_o[0][5]),
    .pscore(ps[0]), .dscore(ds[0]),
    .player_wins(pw_a), .dealer_wins(dw_a), .ties(ti_a)
  );

  card_datapath #(.TALLY_W(2), .CARD_SEED(7)) dut_b (
    .slow_clock(clk), .resetb(resetb),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .player_win_light(lt[1]), .dealer_win_light(lt[0]),
    .pcard1(card_o[1][0]), .pcard2(card_o[1][1]), .pcard3(card_o[1][2]),
    .dcard1(card_o[1][3]), .dcard2(card_o[1][4]), .dcard3(card_o[1][5]),
    .pscore(ps[1]), .dscore(ds[1]),
    .player_wins(pw_b), .dealer_wins(dw_b), .ties(ti_b)
  );

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int score(input int a, input int b, input int c);
    return (val(a) + val(b) + val(c)) % 10;
  endfunction

  function automatic logic [7:0] obs_tally(input int d, input int k);
    if (d == 0) return (k == 0) ? pw_a : (k == 1) ? dw_a : ti_a;
    return (k == 0) ? {6'd0, pw_b} : (k == 1) ? {6'd0, dw_b} : {6'd0, ti_b};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = seed[d];
      for (int k = 0; k < 6; k++) slot[d][k] = 0;
      for (int k = 0; k < 3; k++) tal[d][k] = 0;
    end
    prev_res = 0;
  endtask

  // Drive at the falling edge, update the model at the rising edge, return at the next fall.
  task automatic tick(input logic [5:0] s, input logic [1:0] l);
    int idx;
    ld = s;
    lt = l;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 6; k++) if (s[k]) slot[d][k] = cnt[d];
      cnt[d] = cnt[d] % 13 + 1;
    end
    if (prev_res == 0 && l != 2'b00) begin
      idx = (l == 2'b10) ? 0 : (l == 2'b01) ? 1 : 2;
      for (int d = 0; d < 2; d++) if (tal[d][idx] < maxv[d]) tal[d][idx]++;
    end
    prev_res = int'(l);
    @(negedge clk);
  endtask

  task automatic wait_card(input int v);
    for (int i = 0; i < 13 && cnt[0] != v; i++) tick(6'b0, 2'b00);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (card_o[d][k] !== 4'd0) begin
          errors++;
          $display("FAIL reset_card dut%0d slot%0d got %0d expected 0", d, k, card_o[d][k]);
        end
      end
      checks++;
      if (ps[d] !== 4'd0 || ds[d] !== 4'd0) begin
        errors++;
        $display("FAIL reset_score dut%0d got %0d/%0d expected 0/0", d, ps[d], ds[d]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_tally(d, k) !== 8'd0) begin
          errors++;
          $display("FAIL reset_tally dut%0d idx%0d got %0d expected 0", d, k, obs_tally(d, k));
        end
      end
    end
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
  endtask

  task automatic test_counter();
    for (int i = 0; i < 14; i++) begin
      tick(6'b000001, 2'b00);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (card_o[d][0] !== 4'(slot[d][0]) || card_o[d][0] == 4'd0) begin
          errors++;
          $display("FAIL counter dut%0d step%0d got %0d expected %0d", d, i, card_o[d][0],
                   slot[d][0]);
        end
      end
    end
  endtask

  task automatic test_score();
    wait_card(9);
    tick(6'b000001, 2'b00);
    wait_card(8);
    tick(6'b000010, 2'b00);
    checks++;
    if (card_o[0][0] !== 4'd9 || card_o[0][1] !== 4'd8 || ps[0] !== 4'd7) begin
      errors++;
      $display("FAIL score_9_8 got p1=%0d p2=%0d ps=%0d expected 9 8 7", card_o[0][0],
               card_o[0][1], ps[0]);
    end
    checks++;
    if (ps[1] !== 4'(score(slot[1][0], slot[1][1], slot[1][2]))) begin
      errors++;
      $display("FAIL score_seed7 got %0d expected %0d", ps[1],
               score(slot[1][0], slot[1][1], slot[1][2]));
    end
  endtask

  task automatic test_nine_sum();
    wait_card(13); tick(6'b001000, 2'b00);
    wait_card(10); tick(6'b010000, 2'b00);
    wait_card(12); tick(6'b100000, 2'b00);
    wait_card(9);  tick(6'b000001, 2'b00);
    wait_card(9);  tick(6'b000010, 2'b00);
    wait_card(9);  tick(6'b000100, 2'b00);
    checks++;
    if (ds[0] !== 4'd0 || ps[0] !== 4'd7) begin
      errors++;
      $display("FAIL nine_sum got ds=%0d ps=%0d expected 0 7", ds[0], ps[0]);
    end
    checks++;
    if (ds[1] !== 4'(score(slot[1][3], slot[1][4], slot[1][5]))) begin
      errors++;
      $display("FAIL nine_sum_b got %0d expected %0d", ds[1],
               score(slot[1][3], slot[1][4], slot[1][5]));
    end
  endtask

  task automatic test_tally();
    int p0, d0, t0;
    p0 = tal[0][0]; d0 = tal[0][1]; t0 = tal[0][2];
    for (int i = 0; i < 6; i++) tick(6'b0, 2'b10);
    tick(6'b0, 2'b00);
    for (int i = 0; i < 2; i++) tick(6'b0, 2'b10);
    tick(6'b0, 2'b00);
    checks++;
    if (pw_a !== 8'(p0 + 2) || dw_a !== 8'(d0) || ti_a !== 8'(t0)) begin
      errors++;
      $display("FAIL tally_player got %0d/%0d/%0d expected %0d/%0d/%0d", pw_a, dw_a, ti_a,
               p0 + 2, d0, t0);
    end
    for (int i = 0; i < 3; i++) tick(6'b0, 2'b11);
    tick(6'b0, 2'b00);
    tick(6'b0, 2'b01);
    tick(6'b0, 2'b00);
    checks++;
    if (ti_a !== 8'(t0 + 1) || dw_a !== 8'(d0 + 1)) begin
      errors++;
      $display("FAIL tally_tie_dealer got t=%0d d=%0d expected %0d %0d", ti_a, dw_a, t0 + 1,
               d0 + 1);
    end
    tick(6'b0, 2'b10);
    tick(6'b0, 2'b11);
    tick(6'b0, 2'b00);
    checks++;
    if (pw_a !== 8'(p0 + 3) || ti_a !== 8'(t0 + 1)) begin
      errors++;
      $display("FAIL tally_no_recount got p=%0d t=%0d expected %0d %0d", pw_a, ti_a, p0 + 3,
               t0 + 1);
    end
    for (int i = 0; i < 5; i++) begin
      tick(6'b0, 2'b10);
      tick(6'b0, 2'b00);
    end
    checks++;
    if (pw_b !== 2'd3) begin
      errors++;
      $display("FAIL tally_saturate got %0d expected 3", pw_b);
    end
    checks++;
    if (pw_a !== 8'(tal[0][0])) begin
      errors++;
      $display("FAIL tally_wide got %0d expected %0d", pw_a, tal[0][0]);
    end
  endtask

  task automatic test_async_reset();
    tick(6'b111111, 2'b10);
    #2 resetb = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (card_o[d][0] !== 4'd0 || card_o[d][5] !== 4'd0 || ps[d] !== 4'd0 || ds[d] !== 4'd0
          || obs_tally(d, 0) !== 8'd0 || obs_tally(d, 2) !== 8'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d got p1=%0d d3=%0d ps=%0d ds=%0d pw=%0d ti=%0d", d,
                 card_o[d][0], card_o[d][5], ps[d], ds[d], obs_tally(d, 0), obs_tally(d, 2));
      end
    end
    @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
    tick(6'b001001, 2'b00);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (card_o[d][0] !== 4'(seed[d]) || card_o[d][3] !== 4'(seed[d])) begin
        errors++;
        $display("FAIL seed_simul dut%0d got p1=%0d d1=%0d expected %0d", d, card_o[d][0],
                 card_o[d][3], seed[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] s;
    logic [1:0] l;
    l = 2'b00;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 6; k++) s[k] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) l = 2'($urandom_range(0, 3));
      tick(s, l);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 6; k++) begin
          checks++;
          if (card_o[d][k] !== 4'(slot[d][k])) begin
            errors++;
            $display("FAIL rand_card dut%0d slot%0d cyc%0d got %0d expected %0d", d, k, i,
                     card_o[d][k], slot[d][k]);
          end
        end
        checks++;
        if (ps[d] !== 4'(score(slot[d][0], slot[d][1], slot[d][2]))
            || ds[d] !== 4'(score(slot[d][3], slot[d][4], slot[d][5]))) begin
          errors++;
          $display("FAIL rand_score dut%0d cyc%0d got %0d/%0d expected %0d/%0d", d, i, ps[d],
                   ds[d], score(slot[d][0], slot[d][1], slot[d][2]),
                   score(slot[d][3], slot[d][4], slot[d][5]));
        end
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs_tally(d, k) !== 8'(tal[d][k])) begin
            errors++;
            $display("FAIL rand_tally dut%0d idx%0d cyc%0d got %0d expected %0d", d, k, i,
                     obs_tally(d, k), tal[d][k]);
          end
        end
      end
    end
  endtask

  initial begin
    ld = 6'b0;
    lt = 2'b00;
    resetb = 1'b1;
    model_reset();
    #2 resetb = 1'b0;
    #10;
    test_reset();
    test_counter();
    test_score();
    test_nine_sum();
    test_tally();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
